sealer_timer: RTL and testbench
===============================

// Module: sealer_timer
// PURPOSE
//  Programmable duration timer; responder end of the sealer <-> timer handshake.
//  The sealer FSM raises en with a 3-bit duration code c and waits for ti2.
//  Block counts c*UNIT_TICKS ticks of a prescaled clock, then emits a one-cycle ti2 pulse.
//  If en is still high after the pulse, the block re-arms with the current c.
//  This supports back-to-back timed phases (e.g. c=3'b111 then c=3'b100) without en dropping.
// PARAMETERS
//  TICK_DIV    50000  clk cycles per tick; 1 = tick every cycle (prescaler bypassed)
//  UNIT_TICKS  10     ticks per unit of c; duration N = c*UNIT_TICKS
//  CNT_W       8      width of remaining-tick counter; must hold 7*UNIT_TICKS
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  reset  in   1      asynchronous, active-high
//  en     in   1      timer request from sealer; level, held for the whole timed phase
//  c      in   3      duration code; sampled only on arm (see below)
//  ti2    out  1      done pulse, exactly one clk cycle per completed period
//  busy   out  1      1 while state is RUN
//  rem    out  CNT_W  remaining ticks of current period; 0 outside RUN
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, presc=0, rem=0, ti2=0, busy=0.
//  States: IDLE, RUN, DONE. Outputs are registered/decoded from state only.
//    ti2=1 iff DONE. busy=1 iff RUN.
//  Arm: occurs in IDLE or DONE when en=1 at the clock edge.
//    Latch N=c*UNIT_TICKS (CNT_W-bit, no truncation allowed by parameter rule).
//    Clear presc.
//    If N!=0, go to RUN with rem=N.
//    If N==0 (c=0), go directly to DONE (zero-length period).
//  IDLE: en=0 -> stay.
//  RUN:
//    Each cycle: presc increments.
//    At presc==TICK_DIV-1: presc<=0 and rem<=rem-1.
//    If rem==1 at that edge -> DONE, rem<=0.
//    Duration: exactly N*TICK_DIV cycles in RUN; ti2 high in the following cycle.
//    Abort: en=0 at any RUN edge -> IDLE, rem<=0, presc<=0, no ti2.
//      Abort has priority over the terminal tick on the same edge.
//    c changes during RUN are ignored; value was latched at arm.
//  DONE: lasts exactly one cycle (ti2 pulse is never stretched).
//    en=1 -> re-arm with c as presented in that cycle.
//    en=0 -> IDLE.
//  Back-to-back periods: ti2 high one cycle, then RUN again.
//    No idle cycle is inserted between periods.
//  ti2 is never high on two consecutive cycles, except c=0 with en held.
//    Then DONE->DONE, and ti2 stays high continuously while en=1 and c=0.
//  presc width: $clog2(TICK_DIV), minimum 1. Counters never wrap.
// TESTING
//  T1 basic: TICK_DIV=4, UNIT_TICKS=2, c=3'b100, en=1 from IDLE.
//     -> RUN for 32 cycles, rem 8..1, ti2=1 for 1 cycle.
//     Then en=0 -> IDLE, busy=0.
//  T2 chained: c=3'b111, en held.
//     -> ti2 after 56 RUN cycles.
//     c switched to 3'b100 during the DONE cycle -> next period 32 cycles, second ti2.
//  T3 abort: c=3'b111, drop en after 20 RUN cycles.
//     -> IDLE next edge, rem=0, ti2 never asserted.
//     Re-raise en -> fresh full 56-cycle period.
//  T4 c ignored: change c from 3'b100 to 3'b001 mid-RUN.
//     -> period still 32 cycles.
//  T5 zero code: c=0, en pulsed for 1 cycle.
//     -> ti2=1 exactly one cycle after the arm edge, busy never 1.
//     Same with en held -> ti2 stays 1.
//  T6 reset: assert reset asynchronously mid-RUN (between edges).
//     -> ti2=0, busy=0, rem=0 immediately.
//     After release, en=1 -> normal 32-cycle period (TICK_DIV=1: 8 cycles).

Source files
------------

// File: rtl/sealer_timer.sv
// Duration timer answering the sealer: counts c*UNIT_TICKS prescaled ticks, then pulses ti2 for one cycle.
// Re-arms straight from DONE when en is still high; dropping en during RUN aborts without a pulse.
module sealer_timer #(
  parameter int TICK_DIV   = 50000,
  parameter int UNIT_TICKS = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       c,
  output logic             ti2,
  output logic             busy,
  output logic [CNT_W-1:0] rem
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [CNT_W-1:0] w_n;
  logic             w_tick;

  assign w_n    = CNT_W'(32'(c) * 32'(UNIT_TICKS));
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_rem_nxt   = r_rem;
    case (r_state)
      IDLE, DONE: begin
        // DONE behaves like IDLE for arming, so chained periods need no idle gap
        w_presc_nxt = '0;
        if (en) begin
          if (w_n != '0) begin
            w_state_nxt = RUN;
            w_rem_nxt   = w_n;
          end else begin
            w_state_nxt = DONE;
            w_rem_nxt   = '0;
          end
        end else begin
          w_state_nxt = IDLE;
          w_rem_nxt   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_rem_nxt   = '0;
          w_presc_nxt = '0;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          if (r_rem == CNT_W'(1)) begin
            w_state_nxt = DONE;
            w_rem_nxt   = '0;
          end else begin
            w_rem_nxt = r_rem - 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_presc_nxt = '0;
        w_rem_nxt   = '0;
      end
    endcase
  end

  assign ti2  = (r_state == DONE);
  assign busy = (r_state == RUN);
  assign rem  = r_rem;

endmodule

// File: tb/tb_sealer_timer.sv
// Bench for sealer_timer: prescaled instance (TICK_DIV=4) plus a bypassed one (TICK_DIV=1),
// per-cycle expected {ti2,busy,rem} queued at drive time and compared after each edge.
module tb_sealer_timer;

  typedef struct packed {
    logic       ti2;
    logic       busy;
    logic [7:0] rem;
  } obs_t;

  typedef struct {
    logic [2:0] c;
    int         run_cyc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, en1;
  logic [2:0] c, c1;
  logic       ti2, busy, ti2_1, busy_1;
  logic [7:0] rem, rem_1;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  sealer_timer #(.TICK_DIV(4), .UNIT_TICKS(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .c(c), .ti2(ti2), .busy(busy), .rem(rem)
  );

  sealer_timer #(.TICK_DIV(1), .UNIT_TICKS(2), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .c(c1), .ti2(ti2_1), .busy(busy_1), .rem(rem_1)
  );

  task automatic expect_obs(input logic xt, input logic xb, input int xr);
    obs_t x;
    x.ti2  = xt;
    x.busy = xb;
    x.rem  = 8'(xr);
    exp_q.push_back(x);
  endtask

  task automatic compare(input bit sel, input string nm);
    obs_t x, a;
    x = exp_q.pop_front();
    a = sel ? {ti2_1, busy_1, rem_1} : {ti2, busy, rem};
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s (dut%0d) t=%0t: got ti2=%0b busy=%0b rem=%0d, want ti2=%0b busy=%0b rem=%0d",
               nm, sel, $time, a.ti2, a.busy, a.rem, x.ti2, x.busy, x.rem);
    end
  endtask

  task automatic tick(input bit sel, input logic e, input logic [2:0] cc,
                      input logic xt, input logic xb, input int xr, input string nm);
    if (sel) begin
      en1 = e;
      c1  = cc;
    end else begin
      en = e;
      c  = cc;
    end
    expect_obs(xt, xb, xr);
    @(posedge clk);
    #1;
    compare(sel, nm);
  endtask

  // Arm with cc, hold en for the whole period with c_run shown after the arm edge;
  // ends sampled in the DONE cycle.
  task automatic run_period(input bit sel, input int td, input logic [2:0] cc,
                            input int run_cyc, input logic [2:0] c_run, input string nm);
    int n;
    if (run_cyc == 0) begin
      tick(sel, 1'b1, cc, 1'b1, 1'b0, 0, {nm, "_zero"});
    end else begin
      n = run_cyc / td;
      tick(sel, 1'b1, cc, 1'b0, 1'b1, n, {nm, "_arm"});
      for (int j = 1; j < run_cyc; j++)
        tick(sel, 1'b1, c_run, 1'b0, 1'b1, n - j / td, {nm, "_run"});
      tick(sel, 1'b1, c_run, 1'b1, 1'b0, 0, {nm, "_ti2"});
    end
  endtask

  initial begin
    tbl[0] = '{3'b100, 32};
    tbl[1] = '{3'b001, 8};
    tbl[2] = '{3'b111, 56};
    tbl[3] = '{3'b010, 16};
    tbl[4] = '{3'b011, 24};
    tbl[5] = '{3'b000, 0};

    reset = 1'b1;
    en = 1'b0; c = 3'b000; en1 = 1'b0; c1 = 3'b000;
    #2;
    expect_obs(1'b0, 1'b0, 0);
    compare(0, "reset_state");
    expect_obs(1'b0, 1'b0, 0);
    compare(1, "reset_state1");
    tick(0, 1'b1, 3'b111, 1'b0, 1'b0, 0, "reset_hold");
    reset = 1'b0;
    tick(0, 1'b0, 3'b000, 1'b0, 1'b0, 0, "idle");

    // single periods from IDLE, en dropped in the DONE cycle
    for (int i = 0; i < 6; i++) begin
      run_period(0, 4, tbl[i].c, tbl[i].run_cyc, tbl[i].c, "tbl");
      tick(0, 1'b0, tbl[i].c, 1'b0, 1'b0, 0, "tbl_idle");
      tick(0, 1'b0, tbl[i].c, 1'b0, 1'b0, 0, "tbl_idle2");
    end

    // chained: 7 then 4, c switched during the DONE cycle
    run_period(0, 4, 3'b111, 56, 3'b111, "chain1");
    run_period(0, 4, 3'b100, 32, 3'b100, "chain2");
    tick(0, 1'b0, 3'b100, 1'b0, 1'b0, 0, "chain_idle");

    // abort after 20 RUN cycles, then a fresh full period
    tick(0, 1'b1, 3'b111, 1'b0, 1'b1, 14, "abort_arm");
    for (int j = 1; j < 20; j++)
      tick(0, 1'b1, 3'b111, 1'b0, 1'b1, 14 - j / 4, "abort_run");
    tick(0, 1'b0, 3'b111, 1'b0, 1'b0, 0, "abort_idle");
    tick(0, 1'b0, 3'b111, 1'b0, 1'b0, 0, "abort_no_ti2");
    run_period(0, 4, 3'b111, 56, 3'b111, "rearm");
    tick(0, 1'b0, 3'b000, 1'b0, 1'b0, 0, "rearm_idle");

    // c change mid-RUN is ignored
    run_period(0, 4, 3'b100, 32, 3'b001, "c_ignored");
    tick(0, 1'b0, 3'b001, 1'b0, 1'b0, 0, "c_ign_idle");

    // zero code held: ti2 stays high, then leaves DONE into a real period
    for (int j = 0; j < 4; j++)
      tick(0, 1'b1, 3'b000, 1'b1, 1'b0, 0, "zero_held");
    run_period(0, 4, 3'b001, 8, 3'b001, "zero_to_run");
    tick(0, 1'b0, 3'b000, 1'b0, 1'b0, 0, "zero_idle");

    // async reset between edges mid-RUN
    tick(0, 1'b1, 3'b100, 1'b0, 1'b1, 8, "rst_arm");
    for (int j = 1; j < 10; j++)
      tick(0, 1'b1, 3'b100, 1'b0, 1'b1, 8 - j / 4, "rst_run");
    #2;
    reset = 1'b1;
    #1;
    expect_obs(1'b0, 1'b0, 0);
    compare(0, "rst_async");
    tick(0, 1'b1, 3'b100, 1'b0, 1'b0, 0, "rst_hold2");
    reset = 1'b0;
    run_period(0, 4, 3'b100, 32, 3'b100, "post_rst");
    tick(0, 1'b0, 3'b000, 1'b0, 1'b0, 0, "post_rst_idle");

    // prescaler bypassed: one tick per cycle
    run_period(1, 1, 3'b100, 8, 3'b100, "byp4");
    run_period(1, 1, 3'b111, 14, 3'b111, "byp_chain7");
    tick(1, 1'b0, 3'b000, 1'b0, 1'b0, 0, "byp_idle");
    tick(1, 1'b1, 3'b010, 1'b0, 1'b1, 4, "byp_abort_arm");
    tick(1, 1'b0, 3'b010, 1'b0, 1'b0, 0, "byp_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
